// File: rtl/farm_sensor_conditioner.sv
// Farm-road loop sensor front end: synchronise, debounce, and hold a car request for the
// traffic-light controller, with a hold-off window after each farm green.
module farm_sensor_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_LEN = 4,
    parameter int unsigned HOLDOFF_LEN  = 8,
    parameter int unsigned WAIT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_in,
    input  logic              farm_grant,
    output logic              car_req,
    output logic              sensor_clean,
    output logic [WAIT_W-1:0] wait_cycles,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StServed  = 2'd2,
        StHoldoff = 2'd3
    } state_e;

    // Widths sized so the terminal values fit even at the minimum parameter of 1.
    localparam int unsigned DbW = $clog2(DEBOUNCE_LEN + 1);
    localparam int unsigned HoW = $clog2(HOLDOFF_LEN + 1);
    localparam logic [DbW-1:0]    DbLast  = DbW'(DEBOUNCE_LEN - 1);
    localparam logic [HoW-1:0]    HoLast  = HoW'(HOLDOFF_LEN - 1);
    localparam logic [WAIT_W-1:0] WaitMax = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_sync;
    logic                   clean_q, clean_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    state_e                 state_q, state_d;
    logic [HoW-1:0]         ho_cnt_q, ho_cnt_d;
    logic                   pend_q, pend_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sensor_in};
    end

    always_comb begin
        clean_d  = clean_q;
        db_cnt_d = '0;
        if (s_sync != clean_q) begin
            if (db_cnt_q == DbLast) begin
                clean_d = s_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ho_cnt_d = ho_cnt_q;
        pend_d   = pend_q;
        wait_d   = wait_q;
        unique case (state_q)
            StIdle: begin
                if (clean_q) begin
                    state_d = StArmed;
                    wait_d  = '0;
                end
            end
            StArmed: begin
                if (wait_q != WaitMax) begin
                    wait_d = wait_q + 1'b1;
                end
                // A falling sensor does not cancel; only the grant retires the request.
                if (farm_grant) begin
                    state_d = StServed;
                end
            end
            StServed: begin
                if (!farm_grant) begin
                    state_d  = StHoldoff;
                    ho_cnt_d = HoLast;
                    pend_d   = 1'b0;
                end
            end
            StHoldoff: begin
                if (ho_cnt_q == '0) begin
                    if (pend_q || clean_q) begin
                        state_d = StArmed;
                        wait_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ho_cnt_d = ho_cnt_q - 1'b1;
                    pend_d   = pend_q | clean_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            clean_q  <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= StIdle;
            ho_cnt_q <= '0;
            pend_q   <= 1'b0;
            wait_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            clean_q  <= clean_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            ho_cnt_q <= ho_cnt_d;
            pend_q   <= pend_d;
            wait_q   <= wait_d;
        end
    end

    assign car_req      = (state_q == StArmed);
    assign sensor_clean = clean_q;
    assign wait_cycles  = wait_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Bench for farm_sensor_conditioner: phase table with a scoreboard of expected outputs,
// plus cycle-exact sequences for request latency and grant-on-entry.
module tb_farm_sensor_conditioner;

    logic       clk;
    logic       rst;
    logic       sensor_in;
    logic       farm_grant;
    logic       car_req;
    logic       sensor_clean;
    logic [7:0] wait_cycles;
    logic [1:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int rst;
        int sensor;
        int grant;
        int cycles;
        int req;
        int clean;
        int st;
        int w;
    } vec_t;

    typedef struct {
        int idx;
        int req;
        int clean;
        int st;
        int w;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    farm_sensor_conditioner #(
        .SYNC_STAGES (2),
        .DEBOUNCE_LEN(4),
        .HOLDOFF_LEN (8),
        .WAIT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_in   (sensor_in),
        .farm_grant  (farm_grant),
        .car_req     (car_req),
        .sensor_clean(sensor_clean),
        .wait_cycles (wait_cycles),
        .fsm_state   (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int idx, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s [%0d]: got %0d want %0d", name, idx, actual, expected);
        end
    endtask

    task automatic add(input int r, input int s, input int g, input int n,
                       input int req, input int cl, input int st, input int w);
        vec_t v;
        v.rst = r; v.sensor = s; v.grant = g; v.cycles = n;
        v.req = req; v.clean = cl; v.st = st; v.w = w;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst[0];
            sensor_in  = vecs[i].sensor[0];
            farm_grant = vecs[i].grant[0];
            e.idx = i; e.req = vecs[i].req; e.clean = vecs[i].clean;
            e.st = vecs[i].st; e.w = vecs[i].w;
            sb.push_back(e);
            repeat (vecs[i].cycles) @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check("car_req", e.idx, int'(car_req), e.req);
            check("sensor_clean", e.idx, int'(sensor_clean), e.clean);
            check("fsm_state", e.idx, int'(fsm_state), e.st);
            check("wait_cycles", e.idx, int'(wait_cycles), e.w);
        end
    endtask

    // Edge-by-edge: sensor_clean rises after edge 5, car_req after edge 6.
    task automatic seq_latency();
        rst = 1'b1; sensor_in = 1'b0; farm_grant = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; sensor_in = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("lat_clean", e, int'(sensor_clean), (e >= 5) ? 1 : 0);
            check("lat_req", e, int'(car_req), (e >= 6) ? 1 : 0);
        end
    endtask

    // Grant already high when ARMED is entered: it is honoured one edge later.
    task automatic seq_entry_grant();
        rst = 1'b1; sensor_in = 1'b0; farm_grant = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; sensor_in = 1'b1; farm_grant = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("entry_state", 0, int'(fsm_state), 1);
        check("entry_req", 0, int'(car_req), 1);
        @(posedge clk);
        @(negedge clk);
        check("entry_served", 1, int'(fsm_state), 2);
        check("entry_req_drop", 1, int'(car_req), 0);
        check("entry_wait", 1, int'(wait_cycles), 1);
    endtask

    initial begin
        rst = 1'b1; sensor_in = 1'b0; farm_grant = 1'b0;
        //  rst s  g  cyc  req cl st  wait
        add(1, 0, 0,   2,  0, 0, 0,   0);   // reset
        add(0, 1, 0,   3,  0, 0, 0,   0);   // short bounce
        add(0, 0, 0,  10,  0, 0, 0,   0);   // bounce dropped
        add(0, 1, 0,   5,  0, 0, 0,   0);   // edges 0..4
        add(0, 1, 0,   1,  0, 1, 0,   0);   // edge 5: clean
        add(0, 1, 0,   1,  1, 1, 1,   0);   // edge 6: armed
        add(0, 1, 0,   3,  1, 1, 1,   3);
        add(0, 0, 0,  20,  1, 0, 1,  23);   // sensor gone, request held
        add(0, 0, 1,   1,  0, 0, 2,  24);   // grant
        add(0, 0, 1,   3,  0, 0, 2,  24);
        add(0, 1, 1,   8,  0, 1, 2,  24);   // car waiting during green
        add(0, 1, 0,   1,  0, 1, 3,  24);   // grant falls: hold-off
        add(0, 1, 0,   7,  0, 1, 3,  24);
        add(0, 1, 0,   1,  1, 1, 1,   0);   // hold-off done, re-armed
        add(0, 1, 0,   2,  1, 1, 1,   2);
        add(0, 0, 1,   1,  0, 1, 2,   3);
        add(0, 0, 1,  10,  0, 0, 2,   3);
        add(0, 1, 1,   4,  0, 0, 2,   3);   // 6-cycle pulse starts
        add(0, 1, 0,   1,  0, 0, 3,   3);
        add(0, 1, 0,   1,  0, 1, 3,   3);   // pulse seen in hold-off
        add(0, 0, 0,   6,  0, 0, 3,   3);   // clean low again before expiry
        add(0, 0, 0,   1,  1, 0, 1,   0);   // pend re-arms
        add(0, 0, 1,   1,  0, 0, 2,   1);
        add(0, 0, 0,   1,  0, 0, 3,   1);
        add(0, 0, 0,   7,  0, 0, 3,   1);
        add(0, 0, 0,   1,  0, 0, 0,   1);   // no pend: idle
        add(0, 0, 1,   5,  0, 0, 0,   1);   // grant ignored in idle
        add(0, 1, 0,   7,  1, 1, 1,   0);
        add(0, 1, 0, 300,  1, 1, 1, 255);   // saturates
        add(0, 1, 0,  10,  1, 1, 1, 255);
        add(1, 1, 0,   1,  0, 0, 0,   0);   // reset mid-request
        add(0, 1, 0,   5,  0, 0, 0,   0);   // re-debounce from scratch
        add(0, 1, 0,   1,  0, 1, 0,   0);
        add(0, 1, 0,   1,  1, 1, 1,   0);
        run_table();
        seq_latency();
        seq_entry_grant();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
